// File: rtl/fifo_mdc_param.sv
// First-word-fall-through circular FIFO for MDC actor links, with occupancy and almost-full outputs.
// Defining FIFO_MDC_ERR_FLAGS_EN adds the sticky ovf/udf error outputs.
module fifo_mdc_param #(
  parameter int depth     = 64,
  parameter int size      = 8,
  parameter int af_margin = 2,
  localparam int AW       = $clog2(depth)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [size-1:0] datain,
  input  logic            enw,
  output logic            full,
  output logic            almost_full,
  input  logic            enr,
  output logic            valid,
  output logic [size-1:0] dataout,
  output logic [AW:0]     count
`ifdef FIFO_MDC_ERR_FLAGS_EN
  ,
  output logic            ovf,
  output logic            udf
`endif
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(depth);
  localparam logic [AW:0]   AF_LVL   = (AW+1)'(depth - af_margin);

  logic [size-1:0] mem [depth];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            wr_ok, rd_ok;

  // Flags come only from the registered count, so enw/enr never reach them combinationally.
  assign full        = (count_q == FULL_LVL);
  assign almost_full = (count_q >= AF_LVL);
  assign valid       = (count_q != '0);
  assign count       = count_q;
  assign dataout     = mem[rd_ptr_q];

  // A write while full is allowed only together with a pop.
  assign wr_ok = enw & (~full | enr);
  assign rd_ok = enr & valid;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem[wr_ptr_q] <= datain;
  end

`ifdef FIFO_MDC_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (enw & full & ~enr);
      udf_q <= udf_q | (enr & ~valid & ~enw);
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule

// File: tb/tb_fifo_mdc_param.sv
// Directed self-checking bench for fifo_mdc_param at depth=4, size=8, af_margin=1.
module tb_fifo_mdc_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] datain;
  logic       enw, enr;
  logic       full, almost_full, valid;
  logic [7:0] dataout;
  logic [2:0] count;
`ifdef FIFO_MDC_ERR_FLAGS_EN
  logic       ovf, udf;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  fifo_mdc_param #(.depth(4), .size(8), .af_margin(1)) dut (
    .clk(clk), .rst(rst), .datain(datain), .enw(enw), .full(full),
    .almost_full(almost_full), .enr(enr), .valid(valid), .dataout(dataout),
    .count(count)
`ifdef FIFO_MDC_ERR_FLAGS_EN
    , .ovf(ovf), .udf(udf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] popx [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
  logic [7:0] tail [4] = '{8'hA4, 8'hA5, 8'hA6, 8'hA7};

  task automatic fill_up();
    for (int i = 0; i < 4; i++) begin
      datain = fill[i];
      enw    = 1'b1;
      step();
      chk($sformatf("fill_count%0d", i), 32'(count), 32'(i + 1));
      chk($sformatf("fill_af%0d", i), 32'(almost_full), 32'(i + 1 >= 3));
      chk($sformatf("fill_full%0d", i), 32'(full), 32'(i + 1 == 4));
      chk($sformatf("fill_head%0d", i), 32'(dataout), 32'h11);
    end
    enw = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enw = 1'b0; enr = 1'b0; datain = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);

    fill_up();

    // write at full without a read is dropped
    datain = 8'h55; enw = 1'b1;
    step();
    enw = 1'b0;
    chk("drop_count", 32'(count), 32'd4);
    chk("drop_full", 32'(full), 32'd1);
    chk("drop_head", 32'(dataout), 32'h11);
`ifdef FIFO_MDC_ERR_FLAGS_EN
    chk("ovf_set", 32'(ovf), 32'd1);
`endif

    enr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pop_data%0d", i), 32'(dataout), 32'(fill[i]));
      step();
    end
    chk("drain_valid", 32'(valid), 32'd0);
    chk("drain_count", 32'(count), 32'd0);
    // pop while empty: ignored
    step();
    enr = 1'b0;
    chk("empty_pop_count", 32'(count), 32'd0);
    chk("empty_pop_valid", 32'(valid), 32'd0);
`ifdef FIFO_MDC_ERR_FLAGS_EN
    chk("udf_set", 32'(udf), 32'd1);
    step();
    chk("udf_held", 32'(udf), 32'd1);
    chk("ovf_held", 32'(ovf), 32'd1);
`endif

    fill_up();
    enw = 1'b1; enr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      datain = 8'hA0 + 8'(i);
      chk($sformatf("rw_head%0d", i), 32'(dataout), 32'(popx[i]));
      step();
      chk($sformatf("rw_count%0d", i), 32'(count), 32'd4);
    end
    enw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tail_data%0d", i), 32'(dataout), 32'(tail[i]));
      step();
    end
    enr = 1'b0;
    chk("tail_valid", 32'(valid), 32'd0);

    // empty with simultaneous push/pop: only the write takes effect
    datain = 8'h77; enw = 1'b1; enr = 1'b1;
    step();
    enw = 1'b0; enr = 1'b0;
    chk("er_valid", 32'(valid), 32'd1);
    chk("er_count", 32'(count), 32'd1);
    chk("er_data", 32'(dataout), 32'h77);

    datain = 8'h88; enw = 1'b1;
    step();
    enw = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd2);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b0;
    step();
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
`ifdef FIFO_MDC_ERR_FLAGS_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_udf", 32'(udf), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
